// File: rtl/adder_prefix_pipe_pkg.sv
// Shared constants and helpers for the pipelined Kogge-Stone adder.
package adder_prefix_pipe_pkg;

    localparam int unsigned LEN_DATA      = 32;
    localparam int unsigned LOG2_LEN_DATA = 5;
    // Accept-to-result latency, exported for the issue scoreboard.
    localparam int unsigned ADD_PIPE_LAT  = LOG2_LEN_DATA + 1;

    function automatic int unsigned ks_dist(input int unsigned level);
        return 32'(1) << level;
    endfunction

endpackage

// File: rtl/adder_prefix_pipe_if.sv
// Producer/consumer handshake bundle for adder_prefix_pipe.
interface adder_prefix_pipe_if
    import adder_prefix_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = LEN_DATA
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] gen_in;
    logic [WIDTH-1:0] prop_in;
    logic [WIDTH-1:0] hsum_in;
    logic             cin;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport slave (
        input  in_valid, gen_in, prop_in, hsum_in, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );

    modport master (
        output in_valid, gen_in, prop_in, hsum_in, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );

endinterface

// File: rtl/adder_prefix_pipe_level.sv
// One combinational Kogge-Stone prefix level combining bit i with bit i-DIST.
module adder_prefix_level #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIST  = 1
) (
    input  logic [WIDTH-1:0] i_g,
    input  logic [WIDTH-1:0] i_p,
    output logic [WIDTH-1:0] o_g,
    output logic [WIDTH-1:0] o_p
);

    // Bits below DIST have no partner and pass through unchanged.
    localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'((64'd1 << DIST) - 64'd1);

    always_comb begin
        o_g = i_g | (i_p & (i_g << DIST));
        o_p = i_p & ((i_p << DIST) | LOW_MASK);
    end

endmodule

// File: rtl/adder_prefix_pipe.sv
// Pipelined Kogge-Stone carry tree: one register per prefix level plus a
// registered sum/cout/ovf output stage, with valid/ready flow control and flush.
module adder_prefix_pipe
    import adder_prefix_pipe_pkg::*;
#(
    parameter int unsigned WIDTH  = LEN_DATA,
    parameter int unsigned LEVELS = LOG2_LEN_DATA
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    adder_prefix_pipe_if.slave bus
);

    logic [WIDTH-1:0]  r_g    [LEVELS];
    logic [WIDTH-1:0]  r_p    [LEVELS];
    logic [WIDTH-1:0]  r_hsum [LEVELS];
    logic [LEVELS-1:0] r_cin;
    logic [LEVELS-1:0] r_vld;

    logic              r_out_valid;
    logic [WIDTH-1:0]  r_sum;
    logic              r_cout;
    logic              r_ovf;

    logic [WIDTH-1:0]  w_g_in [LEVELS];
    logic [WIDTH-1:0]  w_p_in [LEVELS];
    logic [WIDTH-1:0]  w_g_nx [LEVELS];
    logic [WIDTH-1:0]  w_p_nx [LEVELS];

    logic              w_en;
    logic              w_accept;
    logic              w_last_load;
    logic [WIDTH-1:0]  w_c;
    logic [WIDTH-1:0]  w_sum;
    logic              w_cout;
    logic              w_ovf;

    // The whole pipe advances together unless a held result is blocked.
    assign w_en        = ~r_out_valid | bus.out_ready;
    assign bus.in_ready = w_en & ~flush;
    assign w_accept    = bus.in_valid & bus.in_ready;
    assign w_last_load = w_en & r_vld[LEVELS-1] & ~flush;

    genvar k;
    generate
        for (k = 0; k < LEVELS; k++) begin : g_level
            if (k == 0) begin : g_first
                assign w_g_in[k] = bus.gen_in;
                assign w_p_in[k] = bus.prop_in;
            end else begin : g_rest
                assign w_g_in[k] = r_g[k-1];
                assign w_p_in[k] = r_p[k-1];
            end

            adder_prefix_level #(
                .WIDTH (WIDTH),
                .DIST  (ks_dist(k))
            ) u_level (
                .i_g (w_g_in[k]),
                .i_p (w_p_in[k]),
                .o_g (w_g_nx[k]),
                .o_p (w_p_nx[k])
            );
        end
    endgenerate

    // Carry into bit i is the full group generate of bits i-1..0.
    always_comb begin
        w_c    = {r_g[LEVELS-1][WIDTH-2:0], r_cin[LEVELS-1]};
        w_sum  = r_hsum[LEVELS-1] ^ w_c;
        w_cout = r_g[LEVELS-1][WIDTH-1];
        w_ovf  = w_cout ^ w_c[WIDTH-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < LEVELS; i++) begin
                r_g[i]    <= '0;
                r_p[i]    <= '0;
                r_hsum[i] <= '0;
            end
            r_cin       <= '0;
            r_vld       <= '0;
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            if (w_en) begin
                for (int unsigned i = 0; i < LEVELS; i++) begin
                    r_g[i] <= w_g_nx[i];
                    r_p[i] <= w_p_nx[i];
                end
                r_hsum[0] <= bus.hsum_in;
                for (int unsigned i = 1; i < LEVELS; i++) begin
                    r_hsum[i] <= r_hsum[i-1];
                end
                r_cin       <= {r_cin[LEVELS-2:0], bus.cin};
                r_vld       <= {r_vld[LEVELS-2:0], w_accept};
                r_out_valid <= r_vld[LEVELS-1];
            end
            // Result fields only move when a live beat lands, so they hold across bubbles.
            if (w_last_load) begin
                r_sum  <= w_sum;
                r_cout <= w_cout;
                r_ovf  <= w_ovf;
            end
            if (flush) begin
                r_vld       <= '0;
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_adder_prefix_pipe.sv
// Scoreboard bench for adder_prefix_pipe: driver pushes expectations, monitor pops on transfer.
module tb_adder_prefix_pipe;
    import adder_prefix_pipe_pkg::*;

    localparam int unsigned W = 32;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          acc;
        bit          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    adder_prefix_pipe_if #(.WIDTH(W)) bus ();

    adder_prefix_pipe #(.WIDTH(W), .LEVELS(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   waits  = 0;
    exp_t q[$];
    exp_t mon_e;

    logic [31:0] ta [16] = '{32'h00000001, 32'h0000FFFF, 32'hFFFF0000, 32'h12345678,
                             32'hAAAAAAAA, 32'hDEADBEEF, 32'h7FFFFFFF, 32'h80000000,
                             32'h00FF00FF, 32'h0F0F0F0F, 32'h13579BDF, 32'hFFFFFFFE,
                             32'h40000000, 32'hC0000000, 32'h01234567, 32'h00000000};
    logic [31:0] tb_b [16] = '{32'h00000001, 32'h00000001, 32'h00010000, 32'h87654321,
                             32'h55555555, 32'hCAFEBABE, 32'h7FFFFFFF, 32'hFFFFFFFF,
                             32'h00FF00FF, 32'hF0F0F0F0, 32'h2468ACE0, 32'h00000001,
                             32'h40000000, 32'hBFFFFFFF, 32'h89ABCDEF, 32'h00000000};
    logic        tc [16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                             1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] s, input logic co, input logic ov, input bit lat);
        exp_t e;
        e.sum = s; e.cout = co; e.ovf = ov; e.acc = 0; e.lat = lat;
        return e;
    endfunction

    // Reference arithmetic: plain 33-bit add and sign-rule overflow.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic ci, input bit lat);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b} + 33'(ci);
        return mk(s[31:0], s[32], (a[31] == b[31]) && (s[31] != a[31]), lat);
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic ci);
        logic [31:0] g;
        g    = a & b;
        g[0] = (a[0] & b[0]) | ((a[0] ^ b[0]) & ci);
        bus.gen_in  = g;
        bus.prop_in = a ^ b;
        bus.hsum_in = a ^ b;
        bus.cin     = ci;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic ci,
                        input exp_t e, input bit push);
        bit done;
        done = 1'b0;
        drive(a, b, ci);
        bus.in_valid = 1'b1;
        for (int n = 0; n < 64 && !done; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                e.acc = cyc;
                if (push) q.push_back(e);
                done = 1'b1;
            end else begin
                waits++;
            end
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        if (!done) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got no in_ready expected accept within 64 cycles");
        end
    endtask

    task automatic wait_drain(input int max);
        for (int n = 0; n < max && q.size() != 0; n++) @(negedge clk);
        chk("drain_queue_left", 32'(q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic wait_out_valid(input int max);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < max && !seen; n++) begin
            @(negedge clk);
            seen = bus.out_valid;
        end
        chk("out_valid_arrival", 32'(seen), 32'd1);
    endtask

    // Monitor: every accepted result is compared against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_output: got sum 0x%08h expected no result", bus.sum);
            end else begin
                mon_e = q.pop_front();
                chk("sum",  bus.sum, mon_e.sum);
                chk("cout", 32'(bus.cout), 32'(mon_e.cout));
                chk("ovf",  32'(bus.ovf),  32'(mon_e.ovf));
                if (mon_e.lat) chk("latency", 32'(cyc - mon_e.acc), 32'd6);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive(32'h0, 32'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sum",       bus.sum,            32'd0);
        chk("rst_cout",      32'(bus.cout),      32'd0);
        chk("rst_ovf",       32'(bus.ovf),       32'd0);
        chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
        @(posedge clk); #1;

        // Cold start and signed overflow corners
        send(32'hFFFFFFFF, 32'h00000000, 1'b1, mk(32'h00000000, 1'b1, 1'b0, 1'b1), 1'b1);
        wait_drain(20);
        send(32'h7FFFFFFF, 32'h00000001, 1'b0, mk(32'h80000000, 1'b0, 1'b1, 1'b1), 1'b1);
        send(32'h80000000, 32'h80000000, 1'b0, mk(32'h00000000, 1'b1, 1'b1, 1'b1), 1'b1);
        wait_drain(20);

        // Back-to-back throughput
        waits = 0;
        for (int i = 0; i < 16; i++) send(ta[i], tb_b[i], tc[i], model(ta[i], tb_b[i], tc[i], 1'b1), 1'b1);
        chk("throughput_stalls", 32'(waits), 32'd0);
        wait_drain(30);

        // Backpressure: hold the first result for 4 cycles
        bus.out_ready = 1'b0;
        send(32'h0000FFFF, 32'h00000001, 1'b0, mk(32'h00010000, 1'b0, 1'b0, 1'b0), 1'b1);
        send(32'h00000010, 32'h00000020, 1'b0, mk(32'h00000030, 1'b0, 1'b0, 1'b0), 1'b1);
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, mk(32'hFFFFFFFF, 1'b1, 1'b0, 1'b0), 1'b1);
        wait_out_valid(20);
        drive(32'h00000001, 32'h00000002, 1'b0);
        bus.in_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("stall_in_ready",  32'(bus.in_ready),  32'd0);
            chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_sum",       bus.sum,            32'h00010000);
            chk("stall_cout",      32'(bus.cout),      32'd0);
        end
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        wait_drain(30);

        // Flush: two beats in flight, then flush while a third is offered
        send(32'h00000001, 32'h00000001, 1'b0, mk(32'h2, 1'b0, 1'b0, 1'b0), 1'b0);
        send(32'h00000005, 32'h00000005, 1'b0, mk(32'hA, 1'b0, 1'b0, 1'b0), 1'b0);
        drive(32'h00000100, 32'h00000200, 1'b0);
        bus.in_valid = 1'b1;
        flush        = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", 32'(bus.in_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        send(32'h00000100, 32'h00000200, 1'b0, mk(32'h00000300, 1'b0, 1'b0, 1'b1), 1'b1);
        wait_drain(20);
        repeat (8) @(posedge clk);
        #1;

        // Async reset with beats in flight
        bus.out_ready = 1'b0;
        send(32'h00000003, 32'h00000004, 1'b0, mk(32'h7, 1'b0, 1'b0, 1'b0), 1'b0);
        send(32'h00000005, 32'h00000006, 1'b0, mk(32'hB, 1'b0, 1'b0, 1'b0), 1'b0);
        send(32'h00000007, 32'h00000008, 1'b0, mk(32'hF, 1'b0, 1'b0, 1'b0), 1'b0);
        send(32'h00000009, 32'h0000000A, 1'b0, mk(32'h13, 1'b0, 1'b0, 1'b0), 1'b0);
        wait_out_valid(20);
        chk("pre_rst_sum", bus.sum, 32'h00000007);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_async_sum",       bus.sum,            32'd0);
        @(posedge clk); #3;
        rst           = 1'b0;
        bus.out_ready = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("stale_after_rst", 32'(seen), 32'd0);
        @(posedge clk); #1;
        send(32'h12345678, 32'h11111111, 1'b0, mk(32'h23456789, 1'b0, 1'b0, 1'b1), 1'b1);
        wait_drain(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
